// File: rtl/att_pkg.sv
// Shared definitions for the attestation monitors and the reset sequencer.
// The address defaults are shared with the other monitors.
package att_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    ASSERT   = 2'd1,
    WAIT_VEC = 2'd2,
    RUN      = 2'd3
  } att_state_e;

  localparam int          ATT_NUM_SRC       = 4;
  localparam int          CAUSE_VEC_TO      = ATT_NUM_SRC;
  localparam logic [15:0] ATT_RESET_HANDLER = 16'hFFFE;
  localparam logic [15:0] ATT_SMEM_BASE     = 16'hE000;
  localparam logic [15:0] ATT_SMEM_SIZE     = 16'h1000;

endpackage

// File: rtl/att_pulse_timer.sv
// Loadable down-counter that stops at zero and flags it.
// Has no reset of its own: the owner loads it whenever a count must start.
module att_pulse_timer #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/att_reset_sequencer.sv
// Central reset controller: turns monitor violations into a fixed-length MCU
// reset pulse, then confirms re-entry at the reset vector.
//
// state    | meaning
// BOOT     | power-on / rst_n pulse, violations ignored
// ASSERT   | violation or timeout pulse, late violations only recorded
// WAIT_VEC | reset released, waiting for pc to hit the reset handler
// RUN      | normal operation, busy low
module att_reset_sequencer
  import att_pkg::*;
#(
  parameter int          NUM_SRC       = ATT_NUM_SRC,
  parameter int          RST_PULSE     = 8,
  parameter int          VEC_TIMEOUT   = 16,
  parameter logic [15:0] RESET_HANDLER = ATT_RESET_HANDLER,
  parameter logic [15:0] SMEM_BASE     = ATT_SMEM_BASE,
  parameter logic [15:0] SMEM_SIZE     = ATT_SMEM_SIZE,
  parameter int          CNT_W         = 8
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [15:0]        pc_i,
  input  logic [NUM_SRC-1:0] viol_i,
  input  logic               cause_clr_i,
  output logic               sys_rst_o,
  output logic [NUM_SRC:0]   cause_o,
  output logic [CNT_W-1:0]   kill_cnt_o,
  output logic               busy_o
);

  localparam int PW = $clog2(RST_PULSE);
  localparam int TW = (VEC_TIMEOUT > 1) ? $clog2(VEC_TIMEOUT) : 1;
  localparam logic [PW-1:0] PULSE_LOAD = PW'(RST_PULSE - 1);
  localparam logic [TW-1:0] VEC_LOAD   = TW'(VEC_TIMEOUT - 1);

  att_state_e         state_q, state_d;
  logic               sys_rst_q, sys_rst_d;
  logic               busy_q, busy_d;
  logic [NUM_SRC:0]   cause_q, cause_d;
  logic [CNT_W-1:0]   kill_q, kill_d, kill_inc;
  logic               pulse_start, pulse_zero, to_load, to_zero;
  logic               viol_any, in_smem;
  logic [16:0]        pc_ext, smem_lo, smem_hi;

  // 17-bit compare so BASE+SIZE cannot wrap at the top of memory
  assign pc_ext   = {1'b0, pc_i};
  assign smem_lo  = {1'b0, SMEM_BASE};
  assign smem_hi  = {1'b0, SMEM_BASE} + {1'b0, SMEM_SIZE} - 17'd2;
  assign in_smem  = (pc_ext >= smem_lo) && (pc_ext <= smem_hi);
  assign viol_any = |viol_i;
  assign kill_inc = (&kill_q) ? kill_q : kill_q + CNT_W'(1);

  att_pulse_timer #(.W(PW)) u_pulse_tmr (
    .clk_i      (clk_i),
    .load_i     (!rst_n_i || pulse_start),
    .load_val_i (PULSE_LOAD),
    .dec_i      ((state_q == BOOT) || (state_q == ASSERT)),
    .zero_o     (pulse_zero)
  );

  att_pulse_timer #(.W(TW)) u_vec_tmr (
    .clk_i      (clk_i),
    .load_i     (to_load),
    .load_val_i (VEC_LOAD),
    .dec_i      (state_q == WAIT_VEC),
    .zero_o     (to_zero)
  );

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    kill_d      = kill_q;
    pulse_start = 1'b0;
    to_load     = 1'b0;
    unique case (state_q)
      BOOT: begin
        if (pulse_zero) begin
          state_d = WAIT_VEC;
          to_load = 1'b1;
        end
      end
      ASSERT: begin
        cause_d[NUM_SRC-1:0] = cause_q[NUM_SRC-1:0] | viol_i;
        if (pulse_zero) begin
          state_d = WAIT_VEC;
          to_load = 1'b1;
        end
      end
      WAIT_VEC: begin
        if (viol_any) begin
          state_d              = ASSERT;
          pulse_start          = 1'b1;
          cause_d[NUM_SRC-1:0] = cause_q[NUM_SRC-1:0] | viol_i;
          kill_d               = kill_inc;
        end else if (pc_i == RESET_HANDLER) begin
          state_d = RUN;
        end else if (to_zero) begin
          state_d          = ASSERT;
          pulse_start      = 1'b1;
          cause_d[NUM_SRC] = 1'b1;
          kill_d           = kill_inc;
        end
      end
      RUN: begin
        if (viol_any) begin
          state_d     = ASSERT;
          pulse_start = 1'b1;
          // a clear racing a violation still records the violation
          if (cause_clr_i && in_smem) begin
            cause_d = {1'b0, viol_i};
            kill_d  = CNT_W'(1);
          end else begin
            cause_d[NUM_SRC-1:0] = cause_q[NUM_SRC-1:0] | viol_i;
            kill_d               = kill_inc;
          end
        end else if (cause_clr_i && in_smem) begin
          cause_d = '0;
          kill_d  = '0;
        end
      end
      default: state_d = BOOT;
    endcase
    sys_rst_d = (state_d == BOOT) || (state_d == ASSERT);
    busy_d    = (state_d != RUN);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= BOOT;
      sys_rst_q <= 1'b1;
      busy_q    <= 1'b1;
      cause_q   <= '0;
      kill_q    <= '0;
    end else begin
      state_q   <= state_d;
      sys_rst_q <= sys_rst_d;
      busy_q    <= busy_d;
      cause_q   <= cause_d;
      kill_q    <= kill_d;
    end
  end

  assign sys_rst_o  = sys_rst_q;
  assign busy_o     = busy_q;
  assign cause_o    = cause_q;
  assign kill_cnt_o = kill_q;

endmodule

// File: tb/tb_att_reset_sequencer.sv
// Directed bench for att_reset_sequencer; expectations go through a queue
// and are compared after the clock edge that should produce them.
module tb_att_reset_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc;
  logic [3:0]  viol;
  logic        cause_clr;
  logic        sys_rst;
  logic [4:0]  cause;
  logic [7:0]  kill_cnt;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  att_reset_sequencer dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .pc_i        (pc),
    .viol_i      (viol),
    .cause_clr_i (cause_clr),
    .sys_rst_o   (sys_rst),
    .cause_o     (cause),
    .kill_cnt_o  (kill_cnt),
    .busy_o      (busy)
  );

  function automatic logic [15:0] mk(logic sr, logic bz, logic [4:0] c, logic [7:0] k);
    return {1'b0, sr, bz, c, k};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(string tag, logic [15:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic pop_cmp(logic [15:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: got %0h with no expectation queued", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: got %0h expected %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic cmp_st();
    pop_cmp(mk(sys_rst, busy, cause, kill_cnt));
  endtask

  task automatic measure_high(output int n);
    n = 0;
    while (sys_rst === 1'b1 && n < 64) begin
      n++;
      tick();
    end
  endtask

  task automatic measure_low(output int n);
    n = 0;
    while (sys_rst === 1'b0 && n < 64) begin
      n++;
      tick();
    end
  endtask

  // called right after sys_rst falls; pc hits the handler on the 3rd WAIT_VEC cycle
  task automatic go_run(string tag, logic [4:0] c, logic [7:0] k);
    push({tag, "_wait"}, mk(1'b0, 1'b1, c, k));
    tick();
    tick();
    cmp_st();
    pc = 16'hFFFE;
    push({tag, "_run"}, mk(1'b0, 1'b0, c, k));
    tick();
    pc = 16'h4400;
    cmp_st();
  endtask

  initial begin
    int n;
    int m;
    rst_n     = 1'b0;
    pc        = 16'h4400;
    viol      = 4'b0000;
    cause_clr = 1'b0;

    // boot
    push("reset_state", mk(1'b1, 1'b1, 5'b0, 8'd0));
    tick();
    tick();
    cmp_st();
    rst_n = 1'b1;
    push("boot_pulse_len", 16'd8);
    measure_high(n);
    pop_cmp(16'(n));
    go_run("boot", 5'b0, 8'd0);

    // violation in RUN, then vector timeout
    viol = 4'b0010;
    push("run_viol_latency", mk(1'b1, 1'b1, 5'b00010, 8'd1));
    tick();
    viol = 4'b0000;
    cmp_st();
    push("run_viol_pulse_len", 16'd8);
    measure_high(n);
    pop_cmp(16'(n));
    push("vec_timeout_cycles", 16'd16);
    measure_low(n);
    pop_cmp(16'(n));
    push("vec_timeout_state", mk(1'b1, 1'b1, 5'b10010, 8'd2));
    cmp_st();
    push("timeout_pulse_len", 16'd8);
    measure_high(n);
    pop_cmp(16'(n));
    go_run("after_timeout", 5'b10010, 8'd2);

    // cause_clr gating on pc
    cause_clr = 1'b1;
    pc = 16'h4400;
    push("clr_outside_smem", mk(1'b0, 1'b0, 5'b10010, 8'd2));
    tick();
    cmp_st();
    pc = 16'hEFFF;
    push("clr_above_smem", mk(1'b0, 1'b0, 5'b10010, 8'd2));
    tick();
    cmp_st();
    pc = 16'hDFFF;
    push("clr_below_smem", mk(1'b0, 1'b0, 5'b10010, 8'd2));
    tick();
    cmp_st();
    pc = 16'hE010;
    push("clr_in_smem", mk(1'b0, 1'b0, 5'b00000, 8'd0));
    tick();
    cmp_st();
    cause_clr = 1'b0;
    pc = 16'h4400;

    // overlapping violations inside one pulse
    viol = 4'b0001;
    tick();
    viol = 4'b0000;
    tick();
    tick();
    viol = 4'b1000;
    tick();
    viol = 4'b0000;
    push("overlap_pulse_len", 16'd8);
    measure_high(m);
    pop_cmp(16'(3 + m));
    push("overlap_state", mk(1'b0, 1'b1, 5'b01001, 8'd1));
    cmp_st();
    go_run("after_overlap", 5'b01001, 8'd1);

    // clear racing a violation
    pc = 16'hE010;
    cause_clr = 1'b1;
    viol = 4'b0100;
    push("clr_vs_viol", mk(1'b1, 1'b1, 5'b00100, 8'd1));
    tick();
    cmp_st();
    cause_clr = 1'b0;
    viol = 4'b0000;
    pc = 16'h4400;
    measure_high(n);

    // violation and reset vector together in WAIT_VEC
    pc = 16'hFFFE;
    viol = 4'b0001;
    push("viol_beats_vector", mk(1'b1, 1'b1, 5'b00101, 8'd2));
    tick();
    cmp_st();
    viol = 4'b0000;
    pc = 16'h4400;
    measure_high(n);

    // saturation
    for (int i = 0; i < 260; i++) begin
      viol = 4'b0001;
      tick();
      viol = 4'b0000;
      measure_high(n);
    end
    push("kill_saturated", mk(1'b0, 1'b1, 5'b00101, 8'd255));
    cmp_st();

    // reset in the middle of a pulse
    viol = 4'b0010;
    tick();
    viol = 4'b0000;
    tick();
    tick();
    rst_n = 1'b0;
    push("mid_pulse_reset", mk(1'b1, 1'b1, 5'b0, 8'd0));
    tick();
    cmp_st();
    rst_n = 1'b1;
    push("reboot_pulse_len", 16'd8);
    measure_high(n);
    pop_cmp(16'(n));
    go_run("reboot", 5'b0, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/att_reset_sequencer.md
Name: att_reset_sequencer

Overview:
- Central reset controller for the secure-attestation hardware monitors.
- Collects violation flags from the monitor FSMs (proof-of-reset, atomicity, key-access and DMA monitors) and drives the system reset for a guaranteed minimum pulse.
- After release, confirms that the CPU re-enters at the reset handler, and keeps a sticky cause record plus a saturating kill counter.
- Sits between the monitors and the MCU reset input.

Parameters:
- NUM_SRC, 4, number of violation sources.
- RST_PULSE, 8, sys_rst high-time in clk cycles per reset event (>=2).
- VEC_TIMEOUT, 16, cycles allowed after release for pc to reach RESET_HANDLER.
- RESET_HANDLER, 16'hFFFE, reset vector address.
- SMEM_BASE, 16'hE000, secure code region base.
- SMEM_SIZE, 16'h1000, secure code region size in bytes.
- CNT_W, 8, kill counter width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- pc  in  16  current program counter.
- viol  in  NUM_SRC  per-monitor violation flags, level, sampled every cycle.
- cause_clr  in  1  request to clear cause and kill_cnt; honoured only when state is RUN and pc is in SMEM.
- sys_rst  out  1  registered reset to the MCU core, active-high.
- cause  out  NUM_SRC+1  sticky cause record; bit NUM_SRC = vector timeout.
- kill_cnt  out  CNT_W  saturating count of violation-triggered resets.
- busy  out  1  high in any state other than RUN.

Behaviour:
- States: BOOT, ASSERT, WAIT_VEC, RUN. The state, pulse counter and timeout counter are registered. All outputs are registered.
- Define in_smem = (pc >= SMEM_BASE) && (pc <= SMEM_BASE+SMEM_SIZE-2). Compute it at 17-bit width so it does not wrap.
- rst_n=0 at a clk edge:
  - state <= BOOT, sys_rst <= 1, pulse_cnt <= RST_PULSE-1.
  - cause <= 0, kill_cnt <= 0, busy <= 1.
- BOOT: sys_rst=1. Decrement pulse_cnt. At pulse_cnt==0: go to WAIT_VEC, sys_rst <= 0, load to_cnt <= VEC_TIMEOUT-1. viol is ignored in BOOT.
- ASSERT: same pulse behaviour as BOOT, so sys_rst is high for exactly RST_PULSE cycles. A viol arriving during ASSERT ORs into cause[NUM_SRC-1:0]. It does not restart the pulse and does not increment kill_cnt.
- WAIT_VEC: sys_rst=0. Priority order:
  1. Any viol bit: go to ASSERT, cause |= viol, kill_cnt++.
  2. pc==RESET_HANDLER: go to RUN.
  3. to_cnt==0: go to ASSERT, set cause[NUM_SRC], kill_cnt++.
  4. Otherwise decrement to_cnt.
- RUN: sys_rst=0, busy=0. Any viol bit: go to ASSERT, sys_rst <= 1 on the same edge (1-cycle latency from viol to sys_rst), cause |= viol, kill_cnt++, pulse_cnt <= RST_PULSE-1.
- kill_cnt saturates at all-ones and never wraps.
- cause_clr:
  - Honoured only in RUN with in_smem=1. Clears cause and kill_cnt.
  - Ignored in every other case.
  - If cause_clr and viol occur in the same cycle: the violation wins. cause <= viol bits (not cleared), kill_cnt <= 1.
- busy = (state != RUN), registered together with state.
- Simultaneous viol and pc==RESET_HANDLER in WAIT_VEC: viol wins.
- rst_n has priority over everything, including mid-pulse. A rst_n in the middle of a pulse restarts a full BOOT pulse.

Decomposition:
- Shared package att_pkg holds:
  - the state encoding (2-bit localparams BOOT, ASSERT, WAIT_VEC, RUN);
  - RESET_HANDLER, SMEM_BASE and SMEM_SIZE defaults, shared with the other monitors;
  - the cause bit index of the vector timeout.
- One natural sub-module, att_pulse_timer: loadable down-counter with a zero flag. Instance it twice, once for the pulse and once for the vector timeout.

Test Plan:
- Boot: hold rst_n=0 for 2 cycles, then release. Required: sys_rst=1 for exactly 8 cycles after release; drive pc=16'hFFFE on cycle 3 of WAIT_VEC; busy drops the following cycle; cause=0, kill_cnt=0.
- Violation in RUN: viol=4'b0010 for 1 cycle. Required: sys_rst=1 on the next edge for 8 cycles; cause=5'b00010; kill_cnt=1; busy high until pc=16'hFFFE.
- Vector timeout: after a pulse, keep pc=16'h4400 for 16 cycles. Required: re-entry to ASSERT; cause[4]=1; kill_cnt incremented; second 8-cycle pulse.
- Overlapping violations: viol=4'b0001 in RUN, then viol=4'b1000 during the pulse. Required: cause=5'b01001, kill_cnt=1, pulse length still 8.
- cause_clr gating: check three cases.
  - pc=16'h4400 with cause_clr=1: no change.
  - pc=16'hE010 in RUN with cause_clr=1: cause=0, kill_cnt=0.
  - cause_clr together with viol=4'b0100: cause=5'b00100, kill_cnt=1.
- Saturation and reset: force 260 violations with CNT_W=8. Required: kill_cnt holds at 255. Then assert rst_n=0 mid-pulse: all outputs return to their reset values and a fresh 8-cycle BOOT pulse follows.
